// File: rtl/jump_predict_stage_pkg.sv
// Shared decode constants for the fetch-side jump predictor: opcodes,
// out_kind encodings and the link-register test used for call/return hints.
package jump_predict_stage_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_RET    = 2'b11
    } kind_e;

    // x1 (ra) and x5 (t0) are the link registers recognised by call/return hints.
    function automatic logic is_link(input logic [4:0] reg_idx);
        return (reg_idx == 5'd1) || (reg_idx == 5'd5);
    endfunction

endpackage

// File: rtl/jump_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// count; a push when full silently overwrites the oldest entry.
module jump_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    // NOTE: the storage array has no reset; a zero count is what makes its contents invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[top + PTR_W'(1)] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top   <= top + PTR_W'(1);
            count <= (count == FULL) ? count : count + CNT_W'(1);
        end else if (pop && (count != '0)) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    assign top_data = mem[top];
    assign empty    = (count == '0);

endmodule

// File: rtl/jump_predict_stage.sv
// Registered fetch-side control-flow predictor (JAL, backward branches, returns).
// Define RAS_EN to build in the return-address stack; without it JALR never redirects.
module jump_predict_stage
    import jump_predict_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target,
    output logic [1:0]      out_kind
);
    logic            accept;
    logic [6:0]      opcode;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;
    logic            nxt_redirect;
    kind_e           nxt_kind;
    logic [XLEN-1:0] nxt_target;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign opcode   = in_instr[6:0];

    assign j_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    assign b_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};

`ifdef RAS_EN
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [2:0]      funct3;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;

    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign funct3 = in_instr[14:12];

    jump_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept && ras_push),
        .pop       (accept && ras_pop),
        .push_data (in_pc + PC_STEP),
        .top_data  (ras_top),
        .empty     (ras_empty)
    );
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        nxt_redirect = 1'b0;
        nxt_kind     = KIND_NONE;
        nxt_target   = '0;
`ifdef RAS_EN
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
`endif
        case (opcode)
            OP_JAL: begin
                nxt_redirect = 1'b1;
                nxt_kind     = KIND_JAL;
                nxt_target   = in_pc + j_imm;
`ifdef RAS_EN
                ras_push     = is_link(rd);
`endif
            end
            OP_BRANCH: begin
                if (in_instr[31]) begin
                    nxt_redirect = 1'b1;
                    nxt_kind     = KIND_BRANCH;
                    nxt_target   = in_pc + b_imm;
                end
            end
`ifdef RAS_EN
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    if (is_link(rd)) begin
                        ras_push = 1'b1;
                    end else if ((rd == 5'd0) && is_link(rs1) && !ras_empty) begin
                        ras_pop      = 1'b1;
                        nxt_redirect = 1'b1;
                        nxt_kind     = KIND_RET;
                        nxt_target   = ras_top;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= '0;
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_kind     <= KIND_NONE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_instr    <= in_instr;
            out_redirect <= nxt_redirect;
            out_target   <= nxt_target;
            out_kind     <= nxt_kind;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jump_predict_stage.sv
// Self-checking bench for jump_predict_stage: directed steps then random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_jump_predict_stage;
    localparam int XLEN      = 32;
    localparam int RAS_DEPTH = 4;
`ifdef RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_redirect;
    logic [XLEN-1:0] out_target;
    logic [1:0]      out_kind;

    jump_predict_stage #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_redirect (out_redirect),
        .out_target   (out_target),
        .out_kind     (out_kind)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic        m_valid;
    logic        m_redirect;
    logic [1:0]  m_kind;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] ras_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_redirect = 0; m_kind = 0;
        m_target = 0; m_pc = 0; m_instr = 0;
        ras_q.delete();
    endtask

    task automatic ras_push(input logic [31:0] v);
        ras_q.push_back(v);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
    endtask

    function automatic bit link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Prediction from the instruction-set rules, immediates rebuilt arithmetically.
    task automatic predict(input logic [31:0] pc, input logic [31:0] i);
        int imm;
        m_redirect = 0; m_kind = 2'b00; m_target = 0;
        case (i[6:0])
            7'b1101111: begin
                imm = i[31] ? -(1 << 20) : 0;
                imm += int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                m_redirect = 1; m_kind = 2'b01; m_target = pc + 32'(imm);
                if (RAS_ON && link(i[11:7])) ras_push(pc + 32'd4);
            end
            7'b1100011: begin
                imm = i[31] ? -4096 : 0;
                imm += int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (imm < 0) begin
                    m_redirect = 1; m_kind = 2'b10; m_target = pc + 32'(imm);
                end
            end
            7'b1100111: begin
                if (i[14:12] == 3'b000 && RAS_ON) begin
                    if (link(i[11:7])) ras_push(pc + 32'd4);
                    else if (i[11:7] == 5'd0 && link(i[19:15]) && ras_q.size() > 0) begin
                        m_target = ras_q.pop_back();
                        m_redirect = 1; m_kind = 2'b11;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        in_valid = v; in_pc = pc; in_instr = instr; out_ready = rdy; flush = fl;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"},    out_valid,    m_valid);
        chk({tag, ".out_redirect"}, out_redirect, m_redirect);
        chk({tag, ".out_kind"},     out_kind,     m_kind);
        chk({tag, ".out_target"},   out_target,   m_target);
        chk({tag, ".out_pc"},       out_pc,       m_pc);
        chk({tag, ".out_instr"},    out_instr,    m_instr);
    endtask

    // One clock: check in_ready, clock the DUT, advance the model, compare outputs.
    task automatic cycle(input string tag);
        logic exp_ready;
        logic acc;
        #1;
        exp_ready = !flush && (!m_valid || out_ready);
        chk({tag, ".in_ready"}, in_ready, exp_ready);
        acc = in_valid && exp_ready;
        @(posedge clk);
        #1;
        if (flush) m_valid = 0;
        else if (acc) begin
            predict(in_pc, in_instr);
            m_valid = 1; m_pc = in_pc; m_instr = in_instr;
        end else if (out_ready) m_valid = 0;
        check_outputs(tag);
    endtask

    task automatic send(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        drive(1, pc, instr, 1, 0);
        cycle(tag);
        drive(0, 0, 0, 1, 0);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom % 4)
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return {r[31:12], pick_reg(), 7'b1101111};
            1: return {r[31:7], 7'b1100011};
            2: return {r[31:20], 5'd1, 3'b000, pick_reg(), 7'b1100111};
            3: return {r[31:20], (r[0] ? 5'd5 : 5'd1), 3'b000, 5'd0, 7'b1100111};
            4: return {r[31:20], pick_reg(), r[14:12], pick_reg(), 7'b1100111};
            default: return r;
        endcase
    endfunction

    localparam logic [31:0] JAL_X1_8 = 32'h008000EF;
    localparam logic [31:0] RET      = 32'h00008067;

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 1, 0);
        model_reset();
        @(posedge clk); #1;
        check_outputs("reset");
        rst_n = 1;

        // Call, then returns
        send("jal", 32'h100, JAL_X1_8);
        chk("jal.kind_const", out_kind, 32'd1);
        chk("jal.target_const", out_target, 32'h108);
        send("ret1", 32'h200, RET);
        send("ret2", 32'h204, RET);

        // Backward / forward branches
        send("beq_back", 32'h300, 32'hFE000EE3);
        chk("beq_back.kind_const", out_kind, 32'd2);
        chk("beq_back.target_const", out_target, 32'h2FC);
        send("beq_fwd", 32'h304, 32'h00000463);
        chk("beq_fwd.redirect_const", out_redirect, 32'd0);

        // Wrap-around target and pushed link
        send("jal_wrap", 32'hFFFFFFFC, JAL_X1_8);
        chk("jal_wrap.target_const", out_target, 32'h4);
        send("ret_wrap", 32'h400, RET);

        // Overflow the stack: five calls, five returns
        for (int k = 1; k <= 5; k++) send("call5", 32'(k * 16), JAL_X1_8);
        for (int k = 0; k < 5; k++) send("ret5", 32'h600 + 32'(k * 4), RET);

        // Back-pressure: held packet must stay, nothing accepted
        send("pre_stall", 32'h700, JAL_X1_8);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h710, JAL_X1_8, 0, 0);
            cycle("stall");
        end
        drive(1, 32'h720, JAL_X1_8, 0, 1);
        cycle("flush");
        drive(1, 32'h730, JAL_X1_8, 1, 1);
        cycle("flush_rdy");
        send("post_flush_ret", 32'h740, RET);
        send("post_flush_ret2", 32'h744, RET);

        // Reset in the middle of traffic
        send("pre_reset", 32'h800, JAL_X1_8);
        #2 rst_n = 0;
        #1;
        chk("midrst.out_valid", out_valid, 32'd0);
        chk("midrst.out_target", out_target, 32'd0);
        chk("midrst.out_kind", out_kind, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        send("ret_after_reset", 32'h900, RET);

        // Random traffic with stalls and flushes
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 5) != 0, ($urandom % 8 == 0) ? 32'($urandom) : 32'($urandom) & 32'hFFFF_FFFC,
                  rand_instr(), ($urandom % 4) != 0, ($urandom % 16) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jump_predict_stage.md
# jump_predict_stage

Registered fetch-side control-flow predictor, successor to the combinational JAL detector. Sits between instruction fetch and decode: decodes JAL, conditional branches and JALR on each accepted fetch packet and computes a redirect target. Adds XLEN parametrisation, static backward-taken branch prediction, an optional return-address stack, and a valid/ready pipeline register with flush.

## Interface
- XLEN, 32: PC and target width (≥ 32).
- RAS_DEPTH, 4: return-address-stack entries, power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  drops the held packet; no input accepted this cycle.
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  = !flush && (!out_valid || out_ready).
- in_pc  in  XLEN  packet PC.
- in_instr  in  32  packet instruction.
- out_valid  out  1  registered packet valid.
- out_ready  in  1  decode accepts.
- out_pc / out_instr  out  XLEN / 32  registered copies.
- out_redirect  out  1  fetch redirect to out_target requested.
- out_target  out  XLEN  predicted target.
- out_kind  out  2  00 none, 01 JAL, 10 backward branch, 11 return.

## Operation
- Accept = in_valid && in_ready; on accept all outputs load from the decode below; the RAS updates only on accept.
- JAL (opcode 1101111): redirect, kind 01, target = in_pc + sign-extended J-immediate. If rd ∈ {x1,x5}: push in_pc+4.
- Branch (opcode 1100011): B-immediate negative → redirect, kind 10, target = in_pc + imm; non-negative → kind 00, no redirect.
- JALR (opcode 1100111, funct3 000): rd ∈ {x1,x5} → push in_pc+4, no redirect (kind 00). rd = x0 and rs1 ∈ {x1,x5} → return: RAS non-empty → pop, redirect, kind 11, target = popped entry; RAS empty → kind 00, no redirect, no state change. Other JALR: kind 00.
- All other opcodes: kind 00, out_redirect 0, out_target 0.
- Arithmetic modulo 2^XLEN; wrap-around is silent. Misaligned targets are reported unchanged.
- RAS: circular buffer, top pointer and count. Push when full overwrites the oldest entry; count saturates at RAS_DEPTH. Pop decrements count, pointer wraps.
- flush: out_valid cleared at next edge; RAS not modified; flush overrides out_ready.

## Timing
- Latency 1 cycle, in_instr → out_*; all outputs registered.
- Reset: out_valid 0, out_redirect 0, out_kind 00, out_pc/out_target/out_instr 0, RAS count 0, pointer 0.
- out_valid && !out_ready: all out_* held stable, in_ready 0.
- out_valid && out_ready && in_valid: back-to-back, one packet/cycle.
- Reset mid-stream: immediate clear, RAS contents invalid (count 0).

## Configuration
- RAS_EN defined: RAS present as above.
- RAS_EN undefined: no storage; JALR never redirects, pushes/pops ignored, kind 11 never produced; JAL and branch behaviour unchanged.

## Structure
- Shared package: opcode constants (OP_JAL, OP_JALR, OP_BRANCH), out_kind encodings, link-register check (x1/x5).
- Sub-module jump_ras: push/pop/data, parameters XLEN and RAS_DEPTH, instantiated only under RAS_EN.

## Test plan
- Reset, then pc 0x100 instr 0x008000EF (jal x1,+8) → next cycle out_redirect 1, kind 01, target 0x108; RAS holds 0x104.
- Then pc 0x200 instr 0x00008067 (ret) → redirect, kind 11, target 0x104; second ret → kind 00, no redirect.
- pc 0x300 instr 0xFE000EE3 (beq -4) → kind 10, target 0x2FC; forward beq +8 → kind 00.
- JAL +8 at pc 0xFFFFFFFC → target 0x00000004, pushed 0x00000000.
- RAS_DEPTH 4: five calls at pc 0x10,0x20,0x30,0x40,0x50, then five rets → targets 0x54,0x44,0x34,0x24, fifth ret no redirect.
- out_ready 0 for 3 cycles with in_valid 1 → outputs stable, in_ready 0, RAS unchanged; flush with in_valid 1 → nothing accepted, out_valid 0 next cycle.
